// File: rtl/mxrv_ram.sv
// mxrv_ram: single-port byte-enabled data RAM responder with valid/ready request/response handshake
// Ports: clk, rst_n (sync active-low); req_valid_i/req_ready_o request handshake;
//   req_we_i, req_addr_i (byte address), req_wdata_i, req_be_i request payload;
//   rsp_valid_o/rsp_ready_i response handshake; rsp_rdata_o read data; rsp_err_o alignment error.
// Parameters: DEPTH words (power of two), LATENCY wait cycles (0..15).
// Define MXRV_RAM_ALIGN_CHK_EN to reject misaligned accesses with rsp_err_o = 1.
module mxrv_ram #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [31:0] r_mem [DEPTH];
  logic r_ready, r_valid, r_err;
  logic [31:0] r_rdata;
  logic w_hs, w_mis, w_ready_nxt, w_valid_nxt, w_err_nxt, w_unused;
  logic [31:0] w_rdata_nxt;
  logic [AW-1:0] w_idx;
  assign w_hs = rst_n & r_ready & req_valid_i;
  assign w_idx = req_addr_i[AW+1:2];
  assign w_unused = ^req_addr_i;
`ifdef MXRV_RAM_ALIGN_CHK_EN
  assign w_mis = |req_addr_i[1:0];
`else
  assign w_mis = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
      r_valid <= w_valid_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        w_state_nxt = w_hs ? (LATENCY == 0 ? RESP : WAIT) : IDLE;
        w_cnt_nxt   = w_hs ? 4'(LATENCY == 0 ? 0 : LATENCY - 1) : r_cnt;
      end
      WAIT: begin
        w_state_nxt = r_cnt == 4'd0 ? RESP : WAIT;
        w_cnt_nxt   = r_cnt == 4'd0 ? r_cnt : r_cnt - 4'd1;
      end
      RESP:    w_state_nxt = (r_valid & rsp_ready_i) ? IDLE : RESP;
      default: w_state_nxt = IDLE;
    endcase
  end
  // rsp_valid_o rises one cycle after entering RESP, giving a response N+1+LATENCY edges after accept.
  always_comb begin
    w_ready_nxt = w_state_nxt == IDLE;
    w_valid_nxt = r_valid ? ~rsp_ready_i : r_state == RESP;
    w_rdata_nxt = w_hs ? ((req_we_i | w_mis) ? 32'd0 : r_mem[w_idx]) : r_rdata;
    w_err_nxt   = w_hs ? w_mis : r_err;
  end
  always_ff @(posedge clk) begin
    if (w_hs & req_we_i & ~w_mis)
      for (int b = 0; b < 4; b++)
        if (req_be_i[b]) r_mem[w_idx][8*b+:8] <= req_wdata_i[8*b+:8];
  end
  assign req_ready_o = r_ready;
  assign rsp_valid_o = r_valid;
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;
endmodule

// File: tb/tb_mxrv_ram.sv
// tb_mxrv_ram: randomized self-checking bench for mxrv_ram against a word-array reference model
module tb_mxrv_ram;
  localparam int LAT = 1;
  logic clk = 1'b0;
  logic rst_n, req_valid_i, req_ready_o, req_we_i, rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] req_addr_i, req_wdata_i, rsp_rdata_o;
  logic [3:0] req_be_i;
  logic [31:0] mdl [1024];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  mxrv_ram #(.DEPTH(1024), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic mis(input logic [31:0] a);
`ifdef MXRV_RAM_ALIGN_CHK_EN
    return a[1:0] != 2'b00;
`else
    return a[1:0] != 2'b00 && 1'b0;
`endif
  endfunction
  function automatic void mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    if (!mis(a))
      for (int b = 0; b < 4; b++)
        if (be[b]) mdl[a[11:2]][8*b+:8] = d[8*b+:8];
  endfunction
  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input int stall);
    int n;
    logic [31:0] exp_d;
    logic exp_e;
    exp_e = mis(a);
    exp_d = (we || exp_e) ? 32'd0 : mdl[a[11:2]];
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = a; req_wdata_i = d; req_be_i = be;
    rsp_ready_i = (stall == 0);
    n = 0;
    while (!req_ready_o && n < 20) begin tick; n++; end
    chk("req_ready", {31'd0, req_ready_o}, 32'd1);
    tick;
    if (we) mdl_write(a, d, be);
    req_valid_i = 1'b0;
    chk("ready_drop", {31'd0, req_ready_o}, 32'd0);
    n = 0;
    while (!rsp_valid_o && n < 20) begin tick; n++; end
    chk("latency", 32'(n), 32'(LAT + 1));
    chk("rdata", rsp_rdata_o, exp_d);
    chk("err", {31'd0, rsp_err_o}, {31'd0, exp_e});
    if (stall > 0) begin
      req_valid_i = 1'b1; req_we_i = 1'b1; req_wdata_i = ~d; req_be_i = 4'hF;
      for (int i = 0; i < stall; i++) begin
        tick;
        chk("stall_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("stall_rdata", rsp_rdata_o, exp_d);
      end
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
    end
    tick;
    chk("valid_drop", {31'd0, rsp_valid_o}, 32'd0);
    chk("ready_back", {31'd0, req_ready_o}, 32'd1);
    rsp_ready_i = 1'b0;
  endtask
  initial begin
    logic [31:0] a;
    rst_n = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
    req_wdata_i = '0; req_be_i = '0; rsp_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("rst_ready", {31'd0, req_ready_o}, 32'd0);
      chk("rst_valid", {31'd0, rsp_valid_o}, 32'd0);
      chk("rst_rdata", rsp_rdata_o, 32'd0);
      chk("rst_err", {31'd0, rsp_err_o}, 32'd0);
    end
    rst_n = 1'b1;
    tick;
    chk("post_rst_ready", {31'd0, req_ready_o}, 32'd1);
    for (int i = 0; i < 64; i++) txn(1'b1, 32'(i * 4), $urandom(), 4'hF, 0);
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
    chk("deadbeef", mdl[4], 32'hDEADBEEF);
    txn(1'b1, 32'h10, 32'h11223344, 4'b0101, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 3);
    txn(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 1);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 0);
    txn(1'b1, 32'h20, 32'h55555555, 4'h0, 0);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 2);
    txn(1'b1, 32'h13, 32'h99887766, 4'hF, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
    txn(1'b0, 32'h12, 32'h0, 4'h0, 0);
    // write accepted then reset during WAIT: write must persist
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h1C; req_wdata_i = 32'h5A5AA5A5; req_be_i = 4'hF;
    tick;
    mdl_write(32'h1C, 32'h5A5AA5A5, 4'hF);
    req_valid_i = 1'b0; rst_n = 1'b0;
    tick;
    chk("midrst_w_valid", {31'd0, rsp_valid_o}, 32'd0);
    rst_n = 1'b1;
    tick;
    // read accepted then reset during WAIT: no response may appear
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h1C;
    tick;
    req_valid_i = 1'b0; rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("midrst_r_valid", {31'd0, rsp_valid_o}, 32'd0);
    end
    chk("midrst_ready", {31'd0, req_ready_o}, 32'd1);
    txn(1'b0, 32'h1C, 32'h0, 4'h0, 0);
    for (int i = 0; i < 300; i++) begin
      a = ($urandom() & 32'hFFFFF000) | 32'($urandom_range(0, 63) * 4);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      txn(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
